// File: rtl/chip7458_tester.sv
// Sweeps all 1024 input vectors of a 7458 and checks p1y/p2y against the AND-OR equations.
// Optional CHIP7458_TESTER_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module chip7458_tester #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             p1a,
    output logic             p1b,
    output logic             p1c,
    output logic             p1d,
    output logic             p1e,
    output logic             p1f,
    output logic             p2a,
    output logic             p2b,
    output logic             p2c,
    output logic             p2d,
    input  logic             p1y,
    input  logic             p2y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_seen,
    output logic [9:0]       fail_vec
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        FINISH
    } state_t;

    localparam logic [7:0]       CNT_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state, state_nxt;
    logic [9:0]       vec, vec_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic             fail_seen_nxt;
    logic [9:0]       fail_vec_nxt;
    logic             p1y_exp, p2y_exp, mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            vec       <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_seen <= 1'b0;
            fail_vec  <= '0;
        end else begin
            state     <= state_nxt;
            vec       <= vec_nxt;
            cnt       <= cnt_nxt;
            err_count <= err_nxt;
            fail_seen <= fail_seen_nxt;
            fail_vec  <= fail_vec_nxt;
        end
    end

    always_comb begin
        p1y_exp  = (vec[0] & vec[1] & vec[2]) | (vec[3] & vec[4] & vec[5]);
        p2y_exp  = (vec[6] & vec[7]) | (vec[8] & vec[9]);
        mismatch = (p1y != p1y_exp) || (p2y != p2y_exp);
    end

    always_comb begin
        state_nxt     = state;
        vec_nxt       = vec;
        cnt_nxt       = cnt;
        err_nxt       = err_count;
        fail_seen_nxt = fail_seen;
        fail_vec_nxt  = fail_vec;
        unique case (state)
            IDLE, FINISH: begin
                if (start) begin
                    state_nxt     = SETTLE;
                    vec_nxt       = '0;
                    cnt_nxt       = CNT_LOAD;
                    err_nxt       = '0;
                    fail_seen_nxt = 1'b0;
                    fail_vec_nxt  = '0;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_count != ERR_MAX) begin
                        err_nxt = err_count + 1'b1;
                    end
                    if (!fail_seen) begin
                        fail_seen_nxt = 1'b1;
                        fail_vec_nxt  = vec;
                    end
                end
`ifdef CHIP7458_TESTER_STOP_ON_FAIL_EN
                if (mismatch || vec == 10'h3FF) begin
`else
                if (vec == 10'h3FF) begin
`endif
                    state_nxt = FINISH;
                end else begin
                    state_nxt = SETTLE;
                    vec_nxt   = vec + 10'd1;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pins idle low outside a sweep so the chip sees a quiet bus.
    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == FINISH);
    assign pass = done && (err_count == '0);

    assign {p2d, p2c, p2b, p2a, p1f, p1e, p1d, p1c, p1b, p1a} = busy ? vec : 10'd0;

endmodule

// File: tb/tb_chip7458_tester.sv
// Bench for chip7458_tester: golden/faulty/random-fault 7458 models, table-driven sweeps.
// A second instance with an 8-bit error counter checks saturation.
module tb_chip7458_tester;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] pins, pins8;
    logic       p1y, p2y, p1y8, p2y8;
    logic       busy, done, pass, fail_seen;
    logic       busy8, done8, pass8, fail_seen8;
    logic [10:0] err_count;
    logic [7:0]  err_count8;
    logic [9:0]  fail_vec, fail_vec8;

    int         mode;
    int         cset;
    logic [1:0] corr [2][1024];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    chip7458_tester u_dut (
        .clk(clk), .reset(reset), .start(start),
        .p1a(pins[0]), .p1b(pins[1]), .p1c(pins[2]),
        .p1d(pins[3]), .p1e(pins[4]), .p1f(pins[5]),
        .p2a(pins[6]), .p2b(pins[7]), .p2c(pins[8]), .p2d(pins[9]),
        .p1y(p1y), .p2y(p2y),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_seen(fail_seen), .fail_vec(fail_vec)
    );

    chip7458_tester #(.SETTLE_CYCLES(1), .ERR_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start),
        .p1a(pins8[0]), .p1b(pins8[1]), .p1c(pins8[2]),
        .p1d(pins8[3]), .p1e(pins8[4]), .p1f(pins8[5]),
        .p2a(pins8[6]), .p2b(pins8[7]), .p2c(pins8[8]), .p2d(pins8[9]),
        .p1y(p1y8), .p2y(p2y8),
        .busy(busy8), .done(done8), .pass(pass8),
        .err_count(err_count8), .fail_seen(fail_seen8), .fail_vec(fail_vec8)
    );

    function automatic logic [1:0] golden(input int v);
        logic y1, y2;
        y1 = ((v & 7) == 7) || (((v >> 3) & 7) == 7);
        y2 = (((v >> 6) & 3) == 3) || (((v >> 8) & 3) == 3);
        return {y1, y2};
    endfunction

    // Chip model with a selectable fault: 1 p1y stuck 0, 2 p2y stuck 1, 3 random flips.
    always_comb begin
        logic [1:0] y, y8;
        y  = golden(int'(pins));
        y8 = golden(int'(pins8));
        if (mode == 1) begin
            y[1]  = 1'b0;
            y8[1] = 1'b0;
        end
        if (mode == 2) begin
            y[0]  = 1'b1;
            y8[0] = 1'b1;
        end
        if (mode == 3) begin
            y  = y ^ corr[cset][pins];
            y8 = y8 ^ corr[cset][pins8];
        end
        {p1y, p2y}   = y;
        {p1y8, p2y8} = y8;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        else
            passed++;
    endtask

    typedef struct {
        string name;
        int    mode;
        int    cset;
        int    repulse;
        int    err;
        int    fvec;
        bit    fseen;
    } vec_t;

    vec_t tbl [6];

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_pins"}, 32'(pins), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
        chk({tag, "_fseen"}, 32'(fail_seen), 0);
        chk({tag, "_fvec"}, 32'(fail_vec), 0);
        chk({tag, "_err8"}, 32'(err_count8), 0);
        chk({tag, "_busy8"}, 32'(busy8), 0);
    endtask

    task automatic run_sweep(input vec_t t);
        int n, e, e8, cyc;
        e  = t.err;
`ifdef CHIP7458_TESTER_STOP_ON_FAIL_EN
        if (e > 1) e = 1;
        cyc = t.fseen ? (t.fvec + 1) * 2 : 2048;
`else
        cyc = 2048;
`endif
        e8 = (e > 255) ? 255 : e;
        mode = t.mode;
        cset = t.cset;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        chk({t.name, "_busy_rise"}, 32'(busy), 1);
        chk({t.name, "_pins_v0"}, 32'(pins), 0);
        chk({t.name, "_cleared"}, 32'({done, err_count, fail_seen}), 0);
        while (!done && n < 3000) begin
            start = (t.repulse != 0 && n == t.repulse);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({t.name, "_cycles"}, 32'(n), 32'(cyc));
        chk({t.name, "_busy_fall"}, 32'(busy), 0);
        chk({t.name, "_err"}, 32'(err_count), 32'(e));
        chk({t.name, "_fseen"}, 32'(fail_seen), 32'(t.fseen));
        chk({t.name, "_fvec"}, 32'(fail_vec), 32'(t.fvec));
        chk({t.name, "_pass"}, 32'(pass), 32'(e == 0));
        chk({t.name, "_done8"}, 32'(done8), 1);
        chk({t.name, "_err8"}, 32'(err_count8), 32'(e8));
        chk({t.name, "_pass8"}, 32'(pass8), 32'(e == 0));
    endtask

    initial begin
        int cnt, first;
        mode  = 0;
        cset  = 0;
        reset = 1'b1;
        start = 1'b0;

        // Random fault sets; reference counts come from walking the tables.
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 1024; v++)
                corr[s][v] = ($urandom_range(0, 99) < 3 * (s + 1))
                             ? 2'($urandom_range(1, 3)) : 2'b00;
            if (s == 1) begin
                for (int v = 0; v < 1024; v++)
                    if ($urandom_range(0, 1) == 1) corr[s][v] = 2'b11;
            end
        end
        tbl[0] = '{"golden", 0, 0, 100, 0, 0, 0};
        tbl[1] = '{"p1y_stuck0", 1, 0, 0, 240, 10'h007, 1};
        tbl[2] = '{"p2y_stuck1", 2, 0, 0, 576, 10'h000, 1};
        tbl[5] = '{"golden_again", 0, 0, 0, 0, 0, 0};
        for (int s = 0; s < 2; s++) begin
            cnt   = 0;
            first = -1;
            for (int v = 0; v < 1024; v++) begin
                if (corr[s][v] != 2'b00) begin
                    cnt++;
                    if (first < 0) first = v;
                end
            end
            tbl[3 + s] = '{(s == 0) ? "rand_a" : "rand_b", 3, s, 0, cnt,
                           (first < 0) ? 0 : first, first >= 0};
        end

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i]);
            repeat (3) @(posedge clk);
            #1;
            chk({tbl[i].name, "_done_held"}, 32'(done), 1);
        end

        // Reset in the middle of a failing sweep.
        mode  = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 1);
        chk("mid_fseen", 32'(fail_seen), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("mid_reset");
        reset = 1'b0;
        @(posedge clk); #1;
        run_sweep('{"after_reset", 0, 0, 0, 0, 0, 0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
